// File: rtl/fft8_input_framer.sv
// Serial-to-parallel framer ahead of the 8-point FFT: gathers 8 samples into a fill
// buffer, then hands the frame to a held output bank under a valid/ready handshake.
module fft8_input_framer #(
    parameter int unsigned N = 4,
    localparam int unsigned W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    output logic [W-1:0] a0,
    output logic [W-1:0] a1,
    output logic [W-1:0] a2,
    output logic [W-1:0] a3,
    output logic [W-1:0] a4,
    output logic [W-1:0] a5,
    output logic [W-1:0] a6,
    output logic [W-1:0] a7,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   frame_cnt,
    output logic         sync_err
);

    logic [W-1:0] fb_q [8];
    logic [W-1:0] a_q  [8];
    logic [W-1:0] a_d  [8];
    logic [2:0]   wr_idx_q, wr_idx_d;
    logic         fill_full_q, fill_full_d;
    logic         out_valid_q, out_valid_d;
    logic         sync_err_q, sync_err_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         accept;
    logic         transfer;

    assign in_ready = !fill_full_q;
    assign accept   = in_valid && !fill_full_q;
    assign transfer = fill_full_q && (!out_valid_q || out_ready);

    always_comb begin
        wr_idx_d    = wr_idx_q;
        fill_full_d = fill_full_q;
        out_valid_d = out_valid_q;
        sync_err_d  = sync_err_q;
        frame_cnt_d = frame_cnt_q;
        a_d         = a_q;

        if (accept) begin
            if (wr_idx_q == 3'd7) begin
                fill_full_d = 1'b1;
                wr_idx_d    = 3'd0;
                // A frame without its last marker is still emitted, but flagged.
                if (!in_last) begin
                    sync_err_d = 1'b1;
                end
            end else if (in_last) begin
                wr_idx_d   = 3'd0;
                sync_err_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 3'd1;
            end
        end

        // Fill and accept are mutually exclusive, so these never collide on fill_full.
        if (transfer) begin
            a_d         = fb_q;
            out_valid_d = 1'b1;
            fill_full_d = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Fill buffer carries no reset; its contents are only read once fill_full is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            fb_q[wr_idx_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_idx_q    <= 3'd0;
            fill_full_q <= 1'b0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            wr_idx_q    <= wr_idx_d;
            fill_full_q <= fill_full_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            frame_cnt_q <= frame_cnt_d;
            a_q         <= a_d;
        end
    end

    assign a0        = a_q[0];
    assign a1        = a_q[1];
    assign a2        = a_q[2];
    assign a3        = a_q[3];
    assign a4        = a_q[4];
    assign a5        = a_q[5];
    assign a6        = a_q[6];
    assign a7        = a_q[7];
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft8_input_framer.sv
// Bench for fft8_input_framer: directed scenarios plus a frame scoreboard fed from
// observed input handshakes and drained on observed output handshakes.
module tb_fft8_input_framer;

    typedef logic [7:0][15:0] frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] a [8];
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  frame_cnt;
    logic        sync_err;

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t sb [$];
    frame_t cur;
    int     m_idx    = 0;
    int     pops     = 0;
    logic   exp_sync = 1'b0;
    logic   rand_mode = 1'b0;

    always #5 clk = ~clk;

    fft8_input_framer #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .a0       (a[0]),
        .a1       (a[1]),
        .a2       (a[2]),
        .a3       (a[3]),
        .a4       (a[4]),
        .a5       (a[5]),
        .a6       (a[6]),
        .a7       (a[7]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_cnt(frame_cnt),
        .sync_err (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs only change at posedge+1, so at negedge every handshake for the next edge is known.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_idx    = 0;
            pops     = 0;
            exp_sync = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_frame", 32'(out_valid), 32'd0);
                end else begin
                    frame_t f;
                    f = sb.pop_front();
                    pops++;
                    for (int i = 0; i < 8; i++) begin
                        check("frame_word", 32'(a[i]), 32'(f[i]));
                    end
                    check("frame_cnt", 32'(frame_cnt), 32'(pops % 256));
                    check("sync_err", 32'(sync_err), 32'(exp_sync));
                end
            end
            if (in_valid && in_ready) begin
                if (m_idx == 7) begin
                    cur[7] = in_data;
                    sb.push_back(cur);
                    m_idx = 0;
                    if (!in_last) exp_sync = 1'b1;
                end else if (in_last) begin
                    m_idx    = 0;
                    exp_sync = 1'b1;
                end else begin
                    cur[m_idx] = in_data;
                    m_idx++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        logic acc;
        int   n = 0;
        if (rand_mode) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 32'(n), 32'd0);
                $fatal(1, "send stalled");
            end
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        cyc();
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_a0", 32'(a[0]), 32'd0);

        // Basic frame and two-edge latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
        check("basic_in_ready_gap", 32'(in_ready), 32'd0);
        check("basic_not_yet_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc();
        check("basic_out_valid", 32'(out_valid), 32'd1);
        check("basic_a0", 32'(a[0]), 32'h0001);
        check("basic_a7", 32'(a[7]), 32'h0008);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check("basic_in_ready_back", 32'(in_ready), 32'd1);
        drain();

        // Backpressure: two frames held, third refused.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(16'h10 + i), i == 7);
        for (int i = 0; i < 8; i++) send(16'(16'h20 + i), i == 7);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h30;
        in_last  = 1'b0;
        repeat (3) cyc();
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_a0", 32'(a[0]), 32'h10);
        check("bp_stall_a7", 32'(a[7]), 32'h17);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("bp_swap_a0", 32'(a[0]), 32'h20);
        check("bp_swap_a7", 32'(a[7]), 32'h27);
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) send(16'(16'h30 + i), i == 7);
        drain();

        // Early last on the 5th sample.
        for (int i = 0; i < 5; i++) send(16'(16'h50 + i), i == 4);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) cyc();
        check("early_sync_err", 32'(sync_err), 32'd1);
        check("early_no_valid", 32'(out_valid), 32'd0);
        check("early_frame_cnt", 32'(frame_cnt), 32'd4);
        for (int i = 0; i < 8; i++) send(16'(16'hA0 + i), i == 7);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc();
        check("early_clean_a0", 32'(a[0]), 32'hA0);
        drain();

        // Reset with a frame presented and a partial fill.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(16'hC0 + i), i == 7);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) send(16'(16'hD0 + i), 1'b0);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_a0", 32'(a[0]), 32'd0);
        check("mid_rst_a7", 32'(a[7]), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_sync_err", 32'(sync_err), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(16'hE0 + i), i == 7);
        drain();

        // Missing last: frame still emitted, error flagged.
        for (int i = 0; i < 8; i++) send(16'(16'hF0 + i), 1'b0);
        drain();
        check("miss_sync_err", 32'(sync_err), 32'd1);
        check("miss_frame_cnt", 32'(frame_cnt), 32'd2);

        // 256 frames with random gaps and stalls; counter wraps.
        do_reset();
        rand_mode = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int s = 0; s < 8; s++) send(16'(f * 8 + s + 16'h1000), s == 7);
        end
        rand_mode = 1'b0;
        drain();
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        check("wrap_sync_err", 32'(sync_err), 32'd0);
        check("wrap_pops", 32'(pops), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_input_framer.md
Name: fft8_input_framer

Overview:
Upstream feeder for the 8-point FFT datapath. Collects a serial stream of real samples with a valid/ready handshake into 8-sample frames. Presents each frame in parallel on a0..a7, natural order, to the first FFT stage. Holds two frames: one filling, one presented. A frame is held stable under out_valid until out_ready consumes it.

Parameters:
N, 4, data width exponent; sample width W = 2**N (16 bits at default).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low; one clock, sync active-low reset, as decided
in_data  in  W  serial sample
in_valid  in  1  in_data/in_last valid
in_ready  out  1  framer can accept a sample this cycle
in_last  in  1  marks the final (8th) sample of a frame
a0..a7  out  W each  parallel frame to FFT stage 1; a0 = first sample received
out_valid  out  1  a0..a7 hold a complete frame
out_ready  in  1  downstream consumes the frame
frame_cnt  out  8  count of frames transferred to a0..a7; wraps 255->0
sync_err  out  1  sticky framing-error flag

Behaviour:
- Reset (rst=0 at a clock edge), every output register cleared:
  - a0..a7=0, out_valid=0, frame_cnt=0, sync_err=0.
  - Fill buffer contents are don't-care.
  - wr_idx=0, fill_full=0, so in_ready=1 from the first cycle after reset.
- Reset mid-frame discards the partial fill frame and any presented frame.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = !fill_full, driven combinationally from a register only; no dependence on in_valid or out_ready.
- State: fill buffer fb[0..7], 3-bit wr_idx, fill_full flag, output register bank a0..a7 plus out_valid.
- Accept with wr_idx=k<7 and in_last=0: fb[k]<=in_data, wr_idx<=k+1.
- Accept with wr_idx=k<7 and in_last=1 (early last):
  - Partial frame discarded; sample dropped.
  - wr_idx<=0, sync_err<=1, no frame emitted.
- Accept with wr_idx=7:
  - fb[7]<=in_data, fill_full<=1, wr_idx<=0.
  - If in_last=0, sync_err<=1, but the frame is still emitted.
- Transfer occurs when fill_full && (!out_valid || out_ready):
  - a0..a7<=fb[0..7], out_valid<=1, fill_full<=0, frame_cnt<=frame_cnt+1.
- Consume without transfer: out_valid && out_ready && !fill_full -> out_valid<=0. a0..a7 keep their last values.
- Simultaneous consume and transfer: out_valid stays 1, new frame loads, no bubble on out_valid.
- Latency: 8th sample accepted at edge t -> fill_full=1 after t -> transfer at edge t+1 -> out_valid=1 and new a0..a7 visible after t+1.
- Throughput: in_ready is low for exactly one cycle per frame when downstream is ready, i.e. 9 cycles per 8 samples. With out_ready stuck low, the framer holds at most 2 frames (16 samples), then in_ready=0 indefinitely.
- Stability: a0..a7 change only on a transfer edge, never while out_valid=1 && out_ready=0.
- No arithmetic on samples; data passes bit-exact, W bits.
- sync_err is cleared only by reset.

Test Plan:
- Basic frame: reset, then stream 0x0001..0x0008 with in_valid=1 continuously, in_last on the 8th sample, out_ready=1.
  - Expect a0=0x0001..a7=0x0008 and out_valid=1 two edges after the 8th accept.
  - Expect frame_cnt=1, sync_err=0, in_ready low for exactly one cycle.
- Backpressure: out_ready=0, stream 3 frames (values 0x10.., 0x20.., 0x30..).
  - Frame 1 is presented; frame 2 is buffered; in_ready=0 after 16 accepts.
  - a0..a7 stay 0x10..0x17 while stalled.
  - Raise out_ready for 1 cycle: a0..a7 become 0x20..0x27 with out_valid held at 1, and in_ready returns to 1.
- Early last: in_last asserted on the 5th sample.
  - Expect sync_err=1, no out_valid, frame_cnt unchanged.
  - The next 8 samples 0xA0..0xA7 form a clean frame with a0=0xA0.
- Missing last: 8 samples with in_last=0 throughout.
  - Frame is emitted normally, frame_cnt increments, sync_err=1.
- Reset mid-operation: assert rst=0 after 4 accepts with a frame presented.
  - Next cycle: out_valid=0, a0..a7=0, frame_cnt=0, in_ready=1.
  - A following clean frame is emitted correctly.
- Counter wrap and random stalls: 256 frames with random in_valid/out_ready gaps.
  - frame_cnt wraps to 0.
  - Every frame matches the stream in order with no loss or duplication; sync_err=0.
